// File: rtl/cap_pixpack_pkg.sv
// Shared constants, encodings and frame-size lookup for the capture pixel packer.
package cap_pkg;

  localparam int unsigned CAP_PIX_W = 24;
  localparam int unsigned CAP_CNT_W = 21;

  typedef enum logic [1:0] {
    RES_640X480   = 2'd0,
    RES_800X600   = 2'd1,
    RES_1024X768  = 2'd2,
    RES_1280X1024 = 2'd3
  } cap_resol_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAITVS = 2'd1,
    S_CAP    = 2'd2
  } cap_state_e;

  function automatic logic [CAP_CNT_W-1:0] frame_total(input logic [1:0] resol);
    case (cap_resol_e'(resol))
      RES_640X480:  frame_total = CAP_CNT_W'(307200);
      RES_800X600:  frame_total = CAP_CNT_W'(480000);
      RES_1024X768: frame_total = CAP_CNT_W'(786432);
      default:      frame_total = CAP_CNT_W'(1310720);
    endcase
  endfunction

endpackage

// File: rtl/cap_pixpack_if.sv
// FIFO write-side bundle between the pixel packer and the capture FIFO.
interface cap_pixpack_if
  import cap_pkg::*;
#(
  parameter int unsigned PIX_W = CAP_PIX_W
);
  logic               FIFO_WR;
  logic [2*PIX_W-1:0] FIFO_DIN;
  logic               FIFO_FULL;

  modport master (output FIFO_WR, output FIFO_DIN, input FIFO_FULL);
  modport slave  (input FIFO_WR, input FIFO_DIN, output FIFO_FULL);
endinterface

// File: rtl/cap_pixpack_pair.sv
// Pixel pairing stage: joins consecutive accepted pixels into one FIFO word and
// closes a half-filled pair with a zero upper pixel.
module cap_pixpack_pair
  import cap_pkg::*;
#(
  parameter int unsigned PIX_W = CAP_PIX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_vld,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               fifo_full,
  output logic               wr,
  output logic [2*PIX_W-1:0] din,
  output logic               drop
);

  logic               phase_q, phase_d;
  logic               pend_q, pend_d;
  logic               wr_q, wr_d;
  logic [PIX_W-1:0]   lo_q, lo_d;
  logic [PIX_W-1:0]   hi_q, hi_d;
  logic [2*PIX_W-1:0] din_q, din_d;

  always_comb begin
    phase_d = phase_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    pend_d  = 1'b0;
    // Any cycle without an accepted pixel flushes a pending half; covers DE gaps,
    // VSYNC aborts and leaving capture.
    if (pix_vld) begin
      if (!phase_q) begin
        lo_d    = pix_data;
        phase_d = 1'b1;
      end else begin
        hi_d    = pix_data;
        pend_d  = 1'b1;
        phase_d = 1'b0;
      end
    end else if (phase_q) begin
      hi_d    = '0;
      pend_d  = 1'b1;
      phase_d = 1'b0;
    end
    wr_d  = pend_q & ~fifo_full;
    din_d = pend_q ? {hi_q, lo_q} : din_q;
  end

  assign drop = pend_q & fifo_full;
  assign wr   = wr_q;
  assign din  = din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      din_q   <= '0;
    end else begin
      phase_q <= phase_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      din_q   <= din_d;
    end
  end

endmodule

// File: rtl/cap_pixpack.sv
// Capture pixel packer: frames RGB video by VSYNC/CAPON, counts pixels against the
// latched frame size and feeds packed pixel pairs to the capture FIFO.
module cap_pixpack
  import cap_pkg::*;
#(
  parameter int unsigned PIX_W     = CAP_PIX_W,
  parameter int unsigned CNT_W     = CAP_CNT_W,
  // Right-shift applied to frame totals; nonzero only to build short frames.
  parameter int unsigned TOT_SHIFT = 0
) (
  input  logic             ACLK,
  input  logic             ARSTN,
  input  logic [1:0]       RESOL,
  input  logic             CAPON,
  input  logic             VIN_VSYNC,
  input  logic             VIN_DE,
  input  logic [PIX_W-1:0] VIN_DATA,
  cap_pixpack_if.master    fifo,
  output logic             BUSY,
  output logic             FRAME_DONE,
  output logic             OVERFLOW,
  output logic             FRAME_ERR
);

  cap_state_e       state_q, state_d;
  logic [1:0]       resol_q, resol_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] total;
  logic             vs_q, vs_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             vs_rise, pix_vld, drop;

  assign vs_rise = VIN_VSYNC & ~vs_q;
  assign pix_vld = (state_q == S_CAP) & VIN_DE & ~vs_rise;
  assign total   = CNT_W'(frame_total(resol_q) >> TOT_SHIFT);

  cap_pixpack_pair #(.PIX_W(PIX_W)) u_pair (
    .clk      (ACLK),
    .rst_n    (ARSTN),
    .pix_vld  (pix_vld),
    .pix_data (VIN_DATA),
    .fifo_full(fifo.FIFO_FULL),
    .wr       (fifo.FIFO_WR),
    .din      (fifo.FIFO_DIN),
    .drop     (drop)
  );

  always_comb begin
    state_d = state_q;
    resol_d = resol_q;
    cnt_d   = cnt_q;
    vs_d    = VIN_VSYNC;
    done_d  = 1'b0;
    err_d   = err_q;
    ovf_d   = ovf_q | drop;
    case (state_q)
      S_IDLE: begin
        if (!CAPON) begin
          ovf_d = 1'b0;
          err_d = 1'b0;
        end else begin
          state_d = S_WAITVS;
        end
      end
      S_WAITVS: begin
        if (!CAPON) begin
          state_d = S_IDLE;
        end else if (vs_rise) begin
          resol_d = RESOL;
          cnt_d   = '0;
          state_d = S_CAP;
        end
      end
      S_CAP: begin
        // A VSYNC rise before the full count aborts the frame and restarts in place.
        if (vs_rise) begin
          err_d  = 1'b1;
          done_d = 1'b1;
          if (CAPON) begin
            resol_d = RESOL;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (VIN_DE) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == total) begin
            done_d  = 1'b1;
            state_d = CAPON ? S_WAITVS : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CAP);
  end

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      state_q <= S_IDLE;
      resol_q <= '0;
      cnt_q   <= '0;
      vs_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      resol_q <= resol_d;
      cnt_q   <= cnt_d;
      vs_q    <= vs_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;
  assign OVERFLOW   = ovf_q;
  assign FRAME_ERR  = err_q;

endmodule
